// File: rtl/iob_rs232_rx_pkg.sv
// Shared definitions for the RS-232 receiver: byte width, FSM encoding and
// the bit-period derivation from clock and baud rates.
package iob_rs232_rx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    // Clock cycles per line bit, truncated.
    function automatic int calc_div(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Cycles from the start edge to the middle of the start bit.
    function automatic int calc_half(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/iob_rs232_rx_fifo.sv
// First-word-fallthrough receive FIFO. Head entry is always visible on
// data_o; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle.
module iob_rs232_rx_fifo
    import iob_rs232_rx_pkg::*;
#(
    parameter int AW = 2,
    parameter int W  = DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cke_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [AW:0]  level_o
);

    localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign empty_o = (r_level == '0);
    assign full_o  = (r_level == DEPTH);
    assign level_o = r_level;
    assign w_pop   = cke_i && pop_i && !empty_o;
    assign w_push  = cke_i && push_i && (!full_o || w_pop);
    assign data_o  = empty_o ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/iob_rs232_rx.sv
// 8N1 RS-232 receiver with mid-bit sampling, frame-error detection,
// a small FWFT receive FIFO with overrun reporting and RTS flow control.
module iob_rs232_rx
    import iob_rs232_rx_pkg::*;
#(
    parameter int FREQ    = 100000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              rxd_i,
    output logic              rts_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int DIV   = calc_div(FREQ, BAUD);
    localparam int HALF  = calc_half(DIV);
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [CNT_W-1:0]   CNT_BIT     = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF    = CNT_W'(HALF - 1);
    localparam logic [FIFO_AW:0]   RTS_MAX_LVL = (FIFO_AW + 1)'(DEPTH - 2);

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxd;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              w_cnt_zero;
    logic              w_push;
    logic              w_ferr;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FIFO_AW:0]  w_level;
    logic              r_rts;
    logic              r_ferr;
    logic              r_ovr;

    assign w_rxd       = r_sync2;
    assign w_cnt_zero  = (r_cnt == '0);
    assign valid_o     = !w_empty;
    assign w_pop       = valid_o && ready_i;
    assign rts_o       = r_rts;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

    // Two-flop synchroniser for the asynchronous line, idling high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else if (cke_i) begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i)      r_state <= ST_IDLE;
        else if (cke_i) r_state <= w_state_nxt;
    end

    // FSM next-state logic; a high start-bit sample is treated as a glitch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (!w_rxd) w_state_nxt = ST_START;
            ST_START:     if (w_cnt_zero) w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_cnt_zero && (r_bit == 3'd7)) w_state_nxt = ST_STOP;
            ST_STOP:      if (w_cnt_zero) w_state_nxt = w_rxd ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (w_rxd) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: stop-bit sample either delivers the byte or flags an error.
    always_comb begin
        w_push = 1'b0;
        w_ferr = 1'b0;
        if ((r_state == ST_STOP) && w_cnt_zero) begin
            w_push = w_rxd;
            w_ferr = !w_rxd;
        end
    end

    // Bit-period counter and bit index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (cke_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd) r_cnt <= CNT_HALF;
                end
                ST_START: begin
                    if (w_cnt_zero) begin
                        r_cnt <= CNT_BIT;
                        r_bit <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_cnt_zero) begin
                        r_cnt <= CNT_BIT;
                        r_bit <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // LSB-first shift register; every byte overwrites all eight bits.
    always_ff @(posedge clk_i) begin
        if (cke_i && (r_state == ST_DATA) && w_cnt_zero)
            r_shift <= {w_rxd, r_shift[DATA_W-1:1]};
    end

    // Registered status: error/overrun pulses and RTS from current occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            r_rts  <= 1'b1;
        end else if (cke_i) begin
            r_ferr <= w_ferr;
            r_ovr  <= w_push && w_full && !w_pop;
            r_rts  <= (w_level <= RTS_MAX_LVL);
        end
    end

    iob_rs232_rx_fifo #(
        .AW (FIFO_AW),
        .W  (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cke_i   (cke_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (w_pop),
        .data_o  (data_o),
        .empty_o (w_empty),
        .full_o  (w_full),
        .level_o (w_level)
    );

endmodule

// File: tb/tb_iob_rs232_rx.sv
// Bench for iob_rs232_rx: directed frames on the line, a transaction-level
// model (scheduled frame outcomes + byte queue) compared every cycle, and
// hand-computed literal expectations.
module tb_iob_rs232_rx;

    // 64 cycles per bit keeps the run short; start-bit midpoint is 32 cycles.
    localparam int FREQ = 100_000_000;
    localparam int BAUD = 1_562_500;
    localparam int D    = FREQ / BAUD;
    localparam int H    = D / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cke;
    logic       rxd;
    logic       ready;
    logic       rts;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    always #5 clk = ~clk;

    iob_rs232_rx #(
        .FREQ    (FREQ),
        .BAUD    (BAUD),
        .FIFO_AW (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cke_i       (cke),
        .rxd_i       (rxd),
        .rts_o       (rts),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int         at;
        logic       err;
        logic [7:0] b;
    } ev_t;

    ev_t        sched[$];
    logic [7:0] m_q[$];
    logic       m_rts  = 1'b1;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;
    int         ecyc   = 0;
    logic       cke_tog = 1'b0;
    logic       cmp_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            sched.delete();
            m_rts  = 1'b1;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else if (cke) begin
            int         lvl;
            logic       pop;
            logic       push;
            logic       err;
            logic [7:0] b;
            ecyc++;
            lvl  = m_q.size();
            pop  = (lvl > 0) && ready;
            push = 1'b0;
            err  = 1'b0;
            b    = 8'h00;
            if (sched.size() > 0 && sched[0].at == ecyc) begin
                push = !sched[0].err;
                err  = sched[0].err;
                b    = sched[0].b;
                void'(sched.pop_front());
            end
            m_ovr  = push && (lvl == 4) && !pop;
            m_ferr = err;
            m_rts  = (4 - lvl) >= 2;
            if (pop) void'(m_q.pop_front());
            if (push && !m_ovr) m_q.push_back(b);
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    logic [7:0] got[$];
    int         nferr = 0;
    int         novr  = 0;
    int         nvalid = 0;
    int         last_rise = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [11:0] a;
            logic [11:0] e;
            logic        mv;
            mv = (m_q.size() > 0);
            a  = {valid, data, rts, ferr, ovr};
            e  = {mv, (mv ? m_q[0] : 8'h00), m_rts, m_ferr, m_ovr};
            chk("cycle_outputs", 32'(a), 32'(e));
            if (valid && ready && cke) got.push_back(data);
            if (ferr) nferr++;
            if (ovr) novr++;
            if (valid) nvalid++;
            if (valid && !prev_valid) last_rise = ecyc;
            prev_valid = valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (cke_tog) cke = ~cke;
    endtask

    task automatic wait_en(input int n);
        int k = 0;
        while (k < n) begin
            if (cke) k++;
            tick();
        end
    endtask

    // Sends one 8N1 frame; the outcome lands at the stop-bit midpoint:
    // 2 sync cycles + half bit + 9 full bits after the first capture edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t ev;
        ev.at  = ecyc + 1 + 2 + H + 9 * D;
        ev.err = !stop;
        ev.b   = b;
        sched.push_back(ev);
        rxd = 1'b0;
        wait_en(D);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_en(D);
        end
        rxd = stop;
        wait_en(D);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int at5;
        rst = 1'b1; cke = 1'b1; rxd = 1'b1; ready = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick(); tick();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_data",  32'(data),  32'd0);
        chk("reset_rts",   32'(rts),   32'd1);
        chk("reset_ferr",  32'(ferr),  32'd0);
        chk("reset_ovr",   32'(ovr),   32'd0);
        rst = 1'b0;
        wait_en(D);

        // 0x55 with consumer ready: single pop, valid after 2+32+9*64 = 610 cycles
        got.delete(); nvalid = 0;
        e0 = ecyc + 1;
        send_frame(8'h55, 1'b1);
        wait_en(D);
        chk("b55_count",   32'(got.size()), 32'd1);
        chk("b55_data",    32'(got.size() > 0 ? got[0] : 8'hxx), 32'h55);
        chk("b55_latency", 32'(last_rise - e0), 32'd610);
        chk("b55_single",  32'(nvalid), 32'd1);

        // short low glitch (20 cycles, under half a bit): nothing reported
        nvalid = 0; nferr = 0;
        rxd = 1'b0; wait_en(20);
        rxd = 1'b1; wait_en(2 * D);
        chk("glitch_valid", 32'(nvalid), 32'd0);
        chk("glitch_ferr",  32'(nferr),  32'd0);

        // 0xA3 with a low stop bit, then a long break: exactly one error
        nvalid = 0; nferr = 0;
        send_frame(8'hA3, 1'b0);
        wait_en(5000);
        rxd = 1'b1;
        wait_en(2 * D);
        chk("ferr_pulses", 32'(nferr),  32'd1);
        chk("ferr_valid",  32'(nvalid), 32'd0);

        // consumer stalled: 5 bytes, rts drops after the 3rd, 5th overruns
        ready = 1'b0; novr = 0;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        chk("rts_after2", 32'(rts), 32'd1);
        send_frame(8'h03, 1'b1);
        chk("rts_after3", 32'(rts), 32'd0);
        send_frame(8'h04, 1'b1);
        send_frame(8'h05, 1'b1);
        chk("ovr_pulses", 32'(novr), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(data), 32'(i));
            ready = 1'b1; wait_en(1);
            ready = 1'b0;
        end
        wait_en(2);
        chk("drain_empty", 32'(valid), 32'd0);
        chk("drain_rts",   32'(rts),   32'd1);

        // full FIFO with a pop in the push cycle: byte accepted, no overrun
        novr = 0;
        send_frame(8'h21, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h23, 1'b1);
        send_frame(8'h24, 1'b1);
        at5 = ecyc + 1 + 2 + H + 9 * D;
        fork
            send_frame(8'h25, 1'b1);
            begin
                while (ecyc != at5 - 1) begin
                    @(posedge clk); #1;
                end
                ready = 1'b1;
                @(posedge clk); #1;
                ready = 1'b0;
            end
        join
        chk("poppush_ovr",  32'(novr), 32'd0);
        chk("popush_head",  32'(data), 32'h22);
        ready = 1'b1;
        wait_en(8);
        chk("popush_empty", 32'(valid), 32'd0);

        // reset in the middle of bit 4 with one byte already queued
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        rxd = 1'b0; wait_en(D);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0]; wait_en(D);
        end
        wait_en(H);
        rst = 1'b1; rxd = 1'b1;
        tick(); tick();
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data",  32'(data),  32'd0);
        chk("midrst_rts",   32'(rts),   32'd1);
        chk("midrst_ferr",  32'(ferr),  32'd0);
        rst = 1'b0;
        nferr = 0;
        wait_en(2 * D);
        ready = 1'b1; got.delete();
        send_frame(8'h7E, 1'b1);
        wait_en(D);
        chk("midrst_count", 32'(got.size()), 32'd1);
        chk("midrst_byte",  32'(got.size() > 0 ? got[0] : 8'hxx), 32'h7E);
        chk("midrst_noerr", 32'(nferr), 32'd0);

        // back-to-back 0x00, 0xFF with clock enable at 50%
        got.delete();
        cke_tog = 1'b1;
        send_frame(8'h00, 1'b1);
        e0 = ecyc + 1;
        send_frame(8'hFF, 1'b1);
        wait_en(D);
        cke_tog = 1'b0; cke = 1'b1;
        wait_en(4);
        chk("b2b_count", 32'(got.size()), 32'd2);
        chk("b2b_first", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h00);
        chk("b2b_second", 32'(got.size() > 1 ? got[1] : 8'hxx), 32'hFF);
        chk("b2b_latency", 32'(last_rise - e0), 32'd610);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_rs232_rx.md
IOB_RS232_RX -- requirements
Module: iob_rs232_rx

Interface
REQ-001 SHALL have parameter FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_AW, default 2, log2 of receive FIFO depth (depth 4).
REQ-004 SHALL have clk_i, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have cke_i, input, 1, clock enable; when low, all state and outputs hold.
REQ-007 SHALL have rxd_i, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have rts_o, output, 1, flow-control grant to remote transmitter, high = may send.
REQ-009 SHALL have data_o, output, 8, head-of-FIFO byte.
REQ-010 SHALL have valid_o, output, 1, FIFO non-empty.
REQ-011 SHALL have ready_i, input, 1, consumer accept; pop when valid_o && ready_i.
REQ-012 SHALL have frame_err_o, output, 1, one-cycle pulse on bad stop bit.
REQ-013 SHALL have overrun_o, output, 1, one-cycle pulse when a good byte is dropped (FIFO full).

Function
REQ-014 SHALL synchronise rxd_i through 2 flops (reset value 1) before any use; 2-cycle input latency.
REQ-015 SHALL use DIV = FREQ/BAUD (integer, truncated; 868 at defaults) and HALF = DIV/2 (434).
REQ-016 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-017 IDLE: synced rxd = 0 -> START, bit counter loaded HALF-1.
REQ-018 START: counter = 0 -> sample; 0 -> DATA with counter DIV-1, bit index 0; 1 -> IDLE (glitch rejected, nothing reported).
REQ-019 DATA: counter = 0 -> shift sample in LSB-first, reload DIV-1; after 8th bit -> STOP.
REQ-020 STOP: counter = 0 -> sample; 1 -> push byte, IDLE; 0 -> frame_err_o pulse, byte discarded, WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until synced rxd = 1, then IDLE (break condition yields one error only).
REQ-022 Push SHALL occur in the same cycle as the stop-bit sample; valid_o rises the following cycle if FIFO was empty.
REQ-023 FIFO SHALL be first-word-fallthrough; data_o is stable while valid_o && !ready_i.
REQ-024 Push when full SHALL be dropped with overrun_o pulse, unless a pop occurs in the same cycle, in which case push is accepted and no overrun.
REQ-025 Pop and push in same cycle on non-full FIFO SHALL leave occupancy unchanged.
REQ-026 rts_o SHALL be high iff free entries >= 2, registered (1 cycle after occupancy change).
REQ-027 Pointers SHALL wrap modulo 2^FIFO_AW; occupancy counter FIFO_AW+1 bits.

Reset
REQ-028 rst_i (sampled with cke_i ignored) SHALL force: state IDLE, counters 0, FIFO empty, synchroniser 1, valid_o 0, data_o 0, rts_o 1, frame_err_o 0, overrun_o 0.
REQ-029 Reset mid-byte SHALL discard the partial byte; no push or error pulse results from it.

Structure
REQ-030 Package iob_rs232_rx_pkg SHALL hold state encoding, DATA_W = 8, and DIV/HALF derivation.
REQ-031 FIFO SHALL be a sub-module iob_rs232_rx_fifo (synchronous, FWFT, full/empty/level outputs).

Verification
REQ-032 Send 0x55 8N1 at DIV 868, ready_i=1 -> valid_o with data_o=0x55 ~434+9*868 cycles after start edge, single pop.
REQ-033 rxd_i low for 200 cycles then high -> no valid_o, no error pulse, FSM back in IDLE.
REQ-034 Send 0xA3 with stop bit 0 -> frame_err_o one pulse, valid_o stays 0; hold line low 5000 cycles -> no further pulses.
REQ-035 ready_i=0, send 5 bytes 0x01..0x05 -> rts_o low after 3rd, overrun_o on 5th, then pops yield 0x01..0x04.
REQ-036 Assert rst_i at bit 4 of a byte -> all outputs at reset values; next full byte 0x7E received correctly.
REQ-037 Back-to-back bytes 0x00,0xFF (no idle gap), cke_i toggling 50% -> both received, timing scaled by enable rate.
